// File: rtl/prog_loader.sv
// prog_loader: boot-time loader that streams host words into instruction
// memory from address 0, pulses the core start input, then counts run cycles
// until the core reports done (or the run times out).
module prog_loader #(
  parameter int D         = 12,
  parameter int W         = 9,
  parameter int START_CYC = 2,
  parameter int CW        = 16,
  parameter int TIMEOUT   = 4000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_req,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic          im_wr_en,
  output logic [D-1:0]  im_addr,
  output logic [W-1:0]  im_wr_data,
  output logic          start,
  input  logic          core_done,
  output logic          busy,
  output logic          finished,
  output logic          err_ovf,
  output logic          err_tmo,
  output logic [D:0]    word_cnt,
  output logic [CW-1:0] cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_FIN
  } state_t;

  localparam int            SCW      = (START_CYC > 1) ? $clog2(START_CYC) : 1;
  localparam logic [SCW-1:0] SCNT_END = SCW'(START_CYC - 1);
  localparam logic [D:0]    WORD_MAX = {1'b1, {D{1'b0}}};
  localparam bit            TMO_EN   = (TIMEOUT != 0);
  localparam logic [CW-1:0] TMO_CNT  = CW'(TIMEOUT);

  state_t         state_q, state_d;
  logic [SCW-1:0] scnt_q, scnt_d;
  logic           wr_en_q, wr_en_d;
  logic [D-1:0]   addr_q, addr_d;
  logic [W-1:0]   data_q, data_d;
  logic           start_q, start_d;
  logic           busy_q, busy_d;
  logic           finished_q, finished_d;
  logic           err_ovf_q, err_ovf_d;
  logic           err_tmo_q, err_tmo_d;
  logic [D:0]     word_cnt_q, word_cnt_d;
  logic [CW-1:0]  cycle_cnt_q, cycle_cnt_d;

  // Ready is a pure decode of the current state so the host sees it with no lag.
  assign in_ready = (state_q == S_LOAD);

  // Next-state, counter and registered-output computation.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    scnt_d      = scnt_q;
    wr_en_d     = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    err_ovf_d   = err_ovf_q;
    err_tmo_d   = err_tmo_q;
    word_cnt_d  = word_cnt_q;
    cycle_cnt_d = cycle_cnt_q;

    unique case (state_q)
      S_IDLE, S_FIN: begin
        if (load_req) begin
          state_d     = S_LOAD;
          word_cnt_d  = '0;
          cycle_cnt_d = '0;
          err_ovf_d   = 1'b0;
          err_tmo_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          if (word_cnt_q != WORD_MAX) begin
            wr_en_d    = 1'b1;
            addr_d     = word_cnt_q[D-1:0];
            data_d     = in_data;
            word_cnt_d = word_cnt_q + 1'b1;
          end else begin
            err_ovf_d = 1'b1;
          end
          // An overflow flagged on this very word still suppresses the start.
          if (in_last) begin
            state_d = err_ovf_d ? S_FIN : S_START;
            scnt_d  = '0;
          end
        end
      end
      S_START: begin
        // core_done is deliberately ignored: it may still be high from the last run.
        if (scnt_q == SCNT_END) begin
          state_d = S_RUN;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (core_done) begin
          state_d = S_FIN;
        end else begin
          if (cycle_cnt_q != '1) begin
            cycle_cnt_d = cycle_cnt_q + 1'b1;
          end
          if (TMO_EN && (cycle_cnt_d == TMO_CNT)) begin
            state_d   = S_FIN;
            err_tmo_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    start_d    = (state_d == S_START);
    busy_d     = (state_d == S_LOAD) || (state_d == S_START) || (state_d == S_RUN);
    finished_d = (state_d == S_FIN);
  end

  // State and registered outputs; reset clears every output including the write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      scnt_q      <= '0;
      wr_en_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
      word_cnt_q  <= '0;
      cycle_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      scnt_q      <= scnt_d;
      wr_en_q     <= wr_en_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      finished_q  <= finished_d;
      err_ovf_q   <= err_ovf_d;
      err_tmo_q   <= err_tmo_d;
      word_cnt_q  <= word_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign im_wr_en   = wr_en_q;
  assign im_addr    = addr_q;
  assign im_wr_data = data_q;
  assign start      = start_q;
  assign busy       = busy_q;
  assign finished   = finished_q;
  assign err_ovf    = err_ovf_q;
  assign err_tmo    = err_tmo_q;
  assign word_cnt   = word_cnt_q;
  assign cycle_cnt  = cycle_cnt_q;

endmodule
